mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-outstanding request arbiter between the instruction cache, the load/store buffer (LSB) and the byte-serial memory controller. It grants one requester at a time and issues a one-cycle command to the controller. It waits for the controller's completion pulse and routes the read data back to the granted requester. It also squashes speculative reads on pipeline clear and holds I/O stores while the I/O buffer is full.

## Interface
- STARVE_LIMIT, 4: number of consecutive LSB grants, while icache is waiting, before icache is force-granted. Only used with ARB_STARVE_GUARD_EN.
- IO_BASE, 32'h0003_0000: an address is I/O when addr[17:16]==2'b11.
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ready  in  1  global enable; when low, all state and outputs hold
- clear  in  1  pipeline flush (mispredict)
- io_buffer_full  in  1  UART buffer full
- icache_req  in  1  fetch request, held until icache_done
- icache_addr  in  32  fetch address
- icache_done  out  1  one-cycle completion pulse
- icache_ins  out  32  fetched word
- lsb_req  in  1  request, held until lsb_done
- lsb_type  in  1  0 = load, 1 = store
- lsb_addr  in  32  byte address
- lsb_len  in  2  0 = byte, 1 = half, 3 = word
- lsb_wdata  in  32  store data
- lsb_done  out  1  one-cycle completion pulse
- lsb_rdata  out  32  load data, zero-extended by the controller
- mc_valid  out  1  one-cycle command pulse to the controller
- mc_type  out  1  0 = read, 1 = write
- mc_addr  out  32  command address
- mc_len  out  2  command length
- mc_wdata  out  32  command write data
- mc_done  in  1  controller completion pulse
- mc_rdata  in  32  controller read data, valid with mc_done

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: evaluate eligible requests.
  - icache eligible if icache_req && !clear.
  - LSB eligible if lsb_req && !(lsb_type && is_io(lsb_addr) && io_buffer_full).
  - LSB load additionally requires !clear. A store is eligible during clear, because stores are committed.
  - Default priority: LSB over icache.
  - On grant: latch owner and command fields, go to ISSUE.
- ISSUE: mc_valid=1 for exactly one cycle with the latched fields, then go to WAIT.
- WAIT: hold the command fields. On mc_done: if owner is icache, capture mc_rdata into icache_ins; if owner is LSB, capture into lsb_rdata. Then go to RESP.
- RESP: pulse owner_done=1 unless squashed; go to IDLE. Requests are not sampled in RESP, so a held request cannot be granted twice.
- Squash: clear asserted in ISSUE, WAIT or RESP while owner is icache or an LSB load sets the squash flag.
  - A squashed transaction still runs to mc_done, because the controller cannot abort.
  - No done pulse is issued and the data is not written.
  - Squash is cleared on return to IDLE.
  - An LSB store is never squashed.
- Exactly one transaction is outstanding; mc_valid is never asserted outside ISSUE.
- Reset (any state, mid-transaction included): go to IDLE; squash=0; counter=0.
  - All outputs are 0: mc_valid, mc_type, mc_addr, mc_len, mc_wdata, icache_done, icache_ins, lsb_done, lsb_rdata.
  - The controller is reset by the same signal.

## Timing
- Grant sampled in cycle T; mc_valid at T+1; WAIT from T+2.
- mc_done at cycle N → owner_done at N+1 with data stable the same cycle.
- Data outputs hold until the next capture.
- The requester deasserts req at N+2; the arbiter samples again in IDLE at N+2. The minimum gap between mc_valid pulses is therefore 3 cycles after mc_done.
- ready low freezes everything, including the mc_valid level. mc_done is only honoured when ready=1.
- mc_done arriving in IDLE or ISSUE is ignored; this is a protocol error and is flagged by an assertion in simulation.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A 3-bit skip counter increments on each LSB grant made while icache_req is high.
  - When counter ≥ STARVE_LIMIT and icache is eligible, icache wins.
  - The counter resets to 0 on any icache grant.
- ARB_STARVE_GUARD_EN undefined: no counter; strict LSB priority.

## Structure
- Shared def.v header holds:
  - state encodings ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_RESP;
  - LEN codes LEN_BYTE/LEN_HALF/LEN_WORD;
  - IO address decode constant;
  - existing ADDR_LEN/DATA_LEN/MEM_LEN ranges.
- One sub-module: arb_pick. It is the combinational eligibility and grant selector (inputs: requests, clear, io flags, starve counter; outputs: grant_icache, grant_lsb). The state machine stays in mem_arbiter.

## Test plan
- Simultaneous icache_req (addr 0x100) and lsb load (addr 0x2000, len 3): LSB granted first; mc_addr=0x2000 at T+1. After lsb_done, icache is granted with mc_addr=0x100.
- LSB store to 0x30000 with io_buffer_full=1 and icache_req high: icache is served first and the store is held. Drop io_buffer_full → store issued with mc_type=1, mc_addr=0x30000.
- Icache fetch in WAIT, clear pulses 1 cycle, mc_done returns 0xDEADBEEF: no icache_done pulse and icache_ins is unchanged. The next request is accepted normally.
- Store in WAIT with clear asserted: lsb_done still pulses at N+1.
- With ARB_STARVE_GUARD_EN and LSB requesting continuously alongside icache: icache is granted after exactly 4 LSB grants. Without the macro: icache is never granted while LSB requests.
- Reset asserted in WAIT: all outputs are 0 immediately. After deassertion, a new lsb_req is issued at T+1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: state encoding, length codes and I/O decode.
package mem_arbiter_pkg;

    localparam int unsigned AddrLen = 32;
    localparam int unsigned DataLen = 32;
    localparam int unsigned MemLen  = 18;

    localparam logic [1:0] LenByte = 2'd0;
    localparam logic [1:0] LenHalf = 2'd1;
    localparam logic [1:0] LenWord = 2'd3;

    localparam logic [AddrLen-1:0] IoBase = 32'h0003_0000;

    typedef enum logic [1:0] {
        ArbIdle,
        ArbIssue,
        ArbWait,
        ArbResp
    } arb_state_e;

    // I/O space is the top window selected by the two highest memory address bits.
    function automatic logic is_io(input logic [AddrLen-1:0] addr,
                                   input logic [AddrLen-1:0] base);
        return addr[MemLen-1 -: 2] == base[MemLen-1 -: 2];
    endfunction

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational eligibility check and grant selection between icache and LSB.
module arb_pick #(
    parameter int unsigned StarveLimit = 4
) (
    input  logic       icache_req,
    input  logic       lsb_req,
    input  logic       lsb_type,
    input  logic       lsb_is_io,
    input  logic       io_buffer_full,
    input  logic       clear,
    input  logic [2:0] skip_cnt,
    output logic       grant_icache,
    output logic       grant_lsb
);

    logic icache_ok;
    logic lsb_ok;
    logic starved;

    assign icache_ok = icache_req && !clear;
    // Stores are already committed, so a flush does not block them.
    assign lsb_ok    = lsb_req && !(lsb_type && lsb_is_io && io_buffer_full) &&
                       (lsb_type || !clear);
    assign starved   = 32'(skip_cnt) >= StarveLimit;

    assign grant_icache = icache_ok && (!lsb_ok || starved);
    assign grant_lsb    = lsb_ok && !grant_icache;

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between icache, LSB and the byte-serial memory controller.
// Optional icache starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned        STARVE_LIMIT = 4,
    parameter logic [AddrLen-1:0] IO_BASE      = IoBase
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ready,
    input  logic               clear,
    input  logic               io_buffer_full,
    input  logic               icache_req,
    input  logic [AddrLen-1:0] icache_addr,
    output logic               icache_done,
    output logic [DataLen-1:0] icache_ins,
    input  logic               lsb_req,
    input  logic               lsb_type,
    input  logic [AddrLen-1:0] lsb_addr,
    input  logic [1:0]         lsb_len,
    input  logic [DataLen-1:0] lsb_wdata,
    output logic               lsb_done,
    output logic [DataLen-1:0] lsb_rdata,
    output logic               mc_valid,
    output logic               mc_type,
    output logic [AddrLen-1:0] mc_addr,
    output logic [1:0]         mc_len,
    output logic [DataLen-1:0] mc_wdata,
    input  logic               mc_done,
    input  logic [DataLen-1:0] mc_rdata
);

    arb_state_e         state_q, state_d;
    logic               squash_q, squash_d;
    logic               owner_lsb_q, owner_lsb_d;
    logic               type_q, type_d;
    logic [AddrLen-1:0] addr_q, addr_d;
    logic [1:0]         len_q, len_d;
    logic [DataLen-1:0] wdata_q, wdata_d;
    logic [DataLen-1:0] ins_q, ins_d;
    logic [DataLen-1:0] rdata_q, rdata_d;
    logic [2:0]         skip_cnt;
    logic               grant_icache, grant_lsb;
    logic               squashable, squash_now, resp_ok;

`ifdef ARB_STARVE_GUARD_EN
    logic [2:0] skip_q, skip_d;

    assign skip_cnt = skip_q;

    always_comb begin
        skip_d = skip_q;
        if (state_q == ArbIdle) begin
            if (grant_icache) begin
                skip_d = 3'd0;
            end else if (grant_lsb && icache_req && skip_q != 3'd7) begin
                skip_d = skip_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            skip_q <= 3'd0;
        end else if (ready) begin
            skip_q <= skip_d;
        end
    end
`else
    assign skip_cnt = 3'd0;
`endif

    arb_pick #(
        .StarveLimit(STARVE_LIMIT)
    ) u_arb_pick (
        .icache_req    (icache_req),
        .lsb_req       (lsb_req),
        .lsb_type      (lsb_type),
        .lsb_is_io     (is_io(lsb_addr, IO_BASE)),
        .io_buffer_full(io_buffer_full),
        .clear         (clear),
        .skip_cnt      (skip_cnt),
        .grant_icache  (grant_icache),
        .grant_lsb     (grant_lsb)
    );

    // Only fetches and loads are speculative; stores always complete.
    assign squashable = !owner_lsb_q || !type_q;
    assign squash_now = squash_q || (clear && squashable);

    always_comb begin
        state_d     = state_q;
        squash_d    = squash_q;
        owner_lsb_d = owner_lsb_q;
        type_d      = type_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wdata_d     = wdata_q;
        ins_d       = ins_q;
        rdata_d     = rdata_q;
        unique case (state_q)
            ArbIdle: begin
                squash_d = 1'b0;
                if (grant_lsb) begin
                    owner_lsb_d = 1'b1;
                    type_d      = lsb_type;
                    addr_d      = lsb_addr;
                    len_d       = lsb_len;
                    wdata_d     = lsb_wdata;
                    state_d     = ArbIssue;
                end else if (grant_icache) begin
                    owner_lsb_d = 1'b0;
                    type_d      = 1'b0;
                    addr_d      = icache_addr;
                    len_d       = LenWord;
                    wdata_d     = '0;
                    state_d     = ArbIssue;
                end
            end
            ArbIssue: begin
                squash_d = squash_now;
                state_d  = ArbWait;
            end
            ArbWait: begin
                squash_d = squash_now;
                if (mc_done) begin
                    state_d = ArbResp;
                    if (!squash_now) begin
                        if (owner_lsb_q) begin
                            rdata_d = mc_rdata;
                        end else begin
                            ins_d = mc_rdata;
                        end
                    end
                end
            end
            ArbResp: begin
                squash_d = 1'b0;
                state_d  = ArbIdle;
            end
            default: state_d = ArbIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ArbIdle;
            squash_q    <= 1'b0;
            owner_lsb_q <= 1'b0;
            type_q      <= 1'b0;
            addr_q      <= '0;
            len_q       <= 2'd0;
            wdata_q     <= '0;
            ins_q       <= '0;
            rdata_q     <= '0;
        end else if (ready) begin
            state_q     <= state_d;
            squash_q    <= squash_d;
            owner_lsb_q <= owner_lsb_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            ins_q       <= ins_d;
            rdata_q     <= rdata_d;
        end
    end

    assign resp_ok     = (state_q == ArbResp) && !squash_now;
    assign icache_done = resp_ok && !owner_lsb_q;
    assign lsb_done    = resp_ok && owner_lsb_q;
    assign icache_ins  = ins_q;
    assign lsb_rdata   = rdata_q;
    assign mc_valid    = (state_q == ArbIssue);
    assign mc_type     = type_q;
    assign mc_addr     = addr_q;
    assign mc_len      = len_q;
    assign mc_wdata    = wdata_q;

    mc_done_in_window: assert property (@(posedge clk) disable iff (reset)
        (ready && mc_done) |-> (state_q == ArbWait || state_q == ArbResp));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected commands/responses queued at stimulus time.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ready = 1'b1;
    logic        clear = 1'b0;
    logic        io_buffer_full = 1'b0;
    logic        icache_req = 1'b0;
    logic [31:0] icache_addr = '0;
    logic        icache_done;
    logic [31:0] icache_ins;
    logic        lsb_req = 1'b0;
    logic        lsb_type = 1'b0;
    logic [31:0] lsb_addr = '0;
    logic [1:0]  lsb_len = 2'd0;
    logic [31:0] lsb_wdata = '0;
    logic        lsb_done;
    logic [31:0] lsb_rdata;
    logic        mc_valid;
    logic        mc_type;
    logic [31:0] mc_addr;
    logic [1:0]  mc_len;
    logic [31:0] mc_wdata;
    logic        mc_done = 1'b0;
    logic [31:0] mc_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter u_dut (
        .clk           (clk),
        .reset         (reset),
        .ready         (ready),
        .clear         (clear),
        .io_buffer_full(io_buffer_full),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .icache_done   (icache_done),
        .icache_ins    (icache_ins),
        .lsb_req       (lsb_req),
        .lsb_type      (lsb_type),
        .lsb_addr      (lsb_addr),
        .lsb_len       (lsb_len),
        .lsb_wdata     (lsb_wdata),
        .lsb_done      (lsb_done),
        .lsb_rdata     (lsb_rdata),
        .mc_valid      (mc_valid),
        .mc_type       (mc_type),
        .mc_addr       (mc_addr),
        .mc_len        (mc_len),
        .mc_wdata      (mc_wdata),
        .mc_done       (mc_done),
        .mc_rdata      (mc_rdata)
    );

    typedef struct packed {
        logic        typ;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
    } cmd_t;

    typedef struct packed {
        logic        lsb;
        logic [31:0] data;
    } resp_t;

    cmd_t        exp_cmd[$];
    resp_t       exp_resp[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] last_ins = '0;
    logic        prev_valid = 1'b0;
    logic        prev_done = 1'b0;
    cmd_t        mon_c;
    resp_t       mon_r;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag, input int exp_n);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!mc_valid && n < 40);
        check_eq(tag, 32'(n), 32'(exp_n));
    endtask

    task automatic respond(input int lat, input logic [31:0] rdata);
        repeat (lat) step();
        mc_done  = 1'b1;
        mc_rdata = rdata;
        step();
        mc_done  = 1'b0;
        mc_rdata = '0;
    endtask

    task automatic check_zero(input string pfx);
        check_eq({pfx, "_ctrl"}, 32'({mc_valid, mc_type, mc_len, icache_done, lsb_done}), 32'd0);
        check_eq({pfx, "_mc_addr"}, mc_addr, 32'd0);
        check_eq({pfx, "_mc_wdata"}, mc_wdata, 32'd0);
        check_eq({pfx, "_icache_ins"}, icache_ins, 32'd0);
        check_eq({pfx, "_lsb_rdata"}, lsb_rdata, 32'd0);
    endtask

    // Pulses are detected on their rising level so a frozen (ready low) pulse counts once.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (mc_valid && !prev_valid) begin
                if (exp_cmd.size() == 0) begin
                    check_eq("unexpected_cmd", 32'(mc_valid), 32'd0);
                end else begin
                    mon_c = exp_cmd.pop_front();
                    check_eq("cmd_type", 32'(mc_type), 32'(mon_c.typ));
                    check_eq("cmd_addr", mc_addr, mon_c.addr);
                    check_eq("cmd_len", 32'(mc_len), 32'(mon_c.len));
                    if (mon_c.typ) check_eq("cmd_wdata", mc_wdata, mon_c.wdata);
                end
            end
            if ((icache_done || lsb_done) && !prev_done) begin
                if (exp_resp.size() == 0) begin
                    check_eq("unexpected_done", 32'({icache_done, lsb_done}), 32'd0);
                end else begin
                    mon_r = exp_resp.pop_front();
                    check_eq("resp_owner", 32'({icache_done, lsb_done}),
                             32'({!mon_r.lsb, mon_r.lsb}));
                    check_eq("resp_data", lsb_done ? lsb_rdata : icache_ins, mon_r.data);
                end
            end
            prev_valid = mc_valid;
            prev_done  = icache_done || lsb_done;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic ic;
        repeat (2) step();
        check_zero("reset");
        reset = 1'b0;
        step();

        // LSB load beats a simultaneous fetch; fetch follows.
        icache_addr = 32'h100;
        icache_req  = 1'b1;
        lsb_addr    = 32'h2000;
        lsb_len     = 2'd3;
        lsb_type    = 1'b0;
        lsb_req     = 1'b1;
        exp_cmd.push_back('{typ: 1'b0, addr: 32'h2000, len: 2'd3, wdata: 32'h0});
        wait_valid("lsb_first_lat", 1);
        check_eq("lsb_first_addr", mc_addr, 32'h2000);
        exp_resp.push_back('{lsb: 1'b1, data: 32'h1122_3344});
        respond(2, 32'h1122_3344);
        check_eq("lsb_done_n1", 32'(lsb_done), 32'd1);
        check_eq("lsb_rdata_n1", lsb_rdata, 32'h1122_3344);
        lsb_req = 1'b0;
        exp_cmd.push_back('{typ: 1'b0, addr: 32'h100, len: 2'd3, wdata: 32'h0});
        wait_valid("icache_after_lsb_lat", 2);
        ready = 1'b0;
        step();
        check_eq("freeze_valid", 32'(mc_valid), 32'd1);
        ready = 1'b1;
        exp_resp.push_back('{lsb: 1'b0, data: 32'hCAFE_F00D});
        respond(1, 32'hCAFE_F00D);
        check_eq("icache_done_n1", 32'(icache_done), 32'd1);
        last_ins   = 32'hCAFE_F00D;
        icache_req = 1'b0;
        step();

        // I/O store held while the buffer is full; fetch goes first.
        lsb_type       = 1'b1;
        lsb_addr       = 32'h0003_0000;
        lsb_len        = 2'd0;
        lsb_wdata      = 32'hA5;
        io_buffer_full = 1'b1;
        lsb_req        = 1'b1;
        icache_addr    = 32'h200;
        icache_req     = 1'b1;
        exp_cmd.push_back('{typ: 1'b0, addr: 32'h200, len: 2'd3, wdata: 32'h0});
        wait_valid("io_icache_first_lat", 1);
        exp_resp.push_back('{lsb: 1'b0, data: 32'h1357_9BDF});
        respond(1, 32'h1357_9BDF);
        last_ins   = 32'h1357_9BDF;
        icache_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("io_store_held", 32'(mc_valid), 32'd0);
        end
        io_buffer_full = 1'b0;
        exp_cmd.push_back('{typ: 1'b1, addr: 32'h0003_0000, len: 2'd0, wdata: 32'hA5});
        wait_valid("io_store_lat", 1);
        check_eq("io_store_type", 32'(mc_type), 32'd1);
        exp_resp.push_back('{lsb: 1'b1, data: 32'h0});
        respond(1, 32'h0);
        lsb_req = 1'b0;
        step();

        // Fetch squashed by a clear in WAIT; a retry is served normally.
        icache_addr = 32'h300;
        icache_req  = 1'b1;
        exp_cmd.push_back('{typ: 1'b0, addr: 32'h300, len: 2'd3, wdata: 32'h0});
        wait_valid("sq_grant_lat", 1);
        step();
        clear = 1'b1;
        step();
        clear    = 1'b0;
        mc_done  = 1'b1;
        mc_rdata = 32'hDEAD_BEEF;
        step();
        mc_done  = 1'b0;
        mc_rdata = '0;
        check_eq("sq_no_done", 32'(icache_done), 32'd0);
        check_eq("sq_ins_kept", icache_ins, last_ins);
        exp_cmd.push_back('{typ: 1'b0, addr: 32'h300, len: 2'd3, wdata: 32'h0});
        wait_valid("sq_retry_lat", 2);
        exp_resp.push_back('{lsb: 1'b0, data: 32'h0BAD_F00D});
        respond(1, 32'h0BAD_F00D);
        check_eq("sq_retry_ins", icache_ins, 32'h0BAD_F00D);
        last_ins   = 32'h0BAD_F00D;
        icache_req = 1'b0;
        step();

        // Store completes despite clear.
        lsb_type  = 1'b1;
        lsb_addr  = 32'h400;
        lsb_len   = 2'd3;
        lsb_wdata = 32'h1234_5678;
        lsb_req   = 1'b1;
        exp_cmd.push_back('{typ: 1'b1, addr: 32'h400, len: 2'd3, wdata: 32'h1234_5678});
        wait_valid("st_grant_lat", 1);
        step();
        clear    = 1'b1;
        mc_done  = 1'b1;
        mc_rdata = 32'h77;
        exp_resp.push_back('{lsb: 1'b1, data: 32'h77});
        step();
        mc_done = 1'b0;
        check_eq("st_clear_done", 32'(lsb_done), 32'd1);
        clear   = 1'b0;
        lsb_req = 1'b0;
        step();

        // Reset mid-transaction.
        lsb_type = 1'b0;
        lsb_addr = 32'h700;
        lsb_len  = 2'd1;
        lsb_req  = 1'b1;
        exp_cmd.push_back('{typ: 1'b0, addr: 32'h700, len: 2'd1, wdata: 32'h0});
        wait_valid("rw_grant_lat", 1);
        step();
        reset = 1'b1;
        #1;
        check_zero("rst_wait");
        step();
        reset    = 1'b0;
        last_ins = '0;
        lsb_addr = 32'h704;
        exp_cmd.push_back('{typ: 1'b0, addr: 32'h704, len: 2'd1, wdata: 32'h0});
        wait_valid("rw_after_lat", 1);
        exp_resp.push_back('{lsb: 1'b1, data: 32'h2468_ACE0});
        respond(1, 32'h2468_ACE0);
        check_eq("rw_lsb_done", 32'(lsb_done), 32'd1);
        lsb_req = 1'b0;
        step();

        // Continuous LSB loads alongside a fetch.
        lsb_type    = 1'b0;
        lsb_addr    = 32'h500;
        lsb_len     = 2'd3;
        lsb_req     = 1'b1;
        icache_addr = 32'h600;
        icache_req  = 1'b1;
        for (int g = 0; g < 6; g++) begin
`ifdef ARB_STARVE_GUARD_EN
            ic = (g == 4);
`else
            ic = 1'b0;
`endif
            exp_cmd.push_back('{typ: 1'b0, addr: ic ? 32'h600 : 32'h500, len: 2'd3,
                                wdata: 32'h0});
            wait_valid("starve_lat", (g == 0) ? 1 : 2);
            exp_resp.push_back('{lsb: !ic, data: 32'h100 + 32'(g)});
            respond(1, 32'h100 + 32'(g));
            check_eq("starve_done", 32'(ic ? icache_done : lsb_done), 32'd1);
            if (ic) icache_req = 1'b0;
        end
        lsb_req    = 1'b0;
        icache_req = 1'b0;
        repeat (4) step();

        check_eq("cmd_queue_empty", 32'(exp_cmd.size()), 32'd0);
        check_eq("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
